// File: rtl/aq_dtu_pcfifo_dump_ctrl_pkg.sv
// Shared constants and state encoding for the DTU PC FIFO dump sequencer.
package aq_dtu_pcfifo_dump_ctrl_pkg;

   localparam int PCFIFO_DATAW     = 64;
   localparam int PCFIFO_DEPTH     = 16;
   localparam int PCFIFO_PTR_WIDTH = 4;
   localparam int PCFIFO_CNT_WIDTH = 5;

   localparam logic [11:0] CSR_PCFIFO = 12'hfe2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DUMP = 2'd2,
      DONE = 2'd3
   } dump_state_e;

endpackage

// File: rtl/aq_dtu_pcfifo_dump_ctrl.sv
// PC FIFO read-port arbiter: CP0 CSR reads in IDLE, DM burst dump while halted.
module aq_dtu_pcfifo_dump_ctrl
   import aq_dtu_pcfifo_dump_ctrl_pkg::*;
#(
   parameter int DATAW     = PCFIFO_DATAW,
   parameter int DEPTH     = PCFIFO_DEPTH,
   parameter int CNT_WIDTH = PCFIFO_CNT_WIDTH
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst_b,
   input  logic                 cp0_dtu_rreg,
   input  logic [11:0]          cp0_dtu_addr,
   input  logic                 cp0_sw_pcfifo_frz,
   input  logic                 had_dbg_mode,
   input  logic                 rtu_dtu_halt_ack,
   input  logic                 dm_dump_req,
   input  logic [CNT_WIDTH-1:0] dm_dump_cnt,
   input  logic                 dm_dump_rdy,
   input  logic [DATAW-1:0]     pcfifo_regs_data,
   output logic                 dtu_pcfifo_frz,
   output logic                 dtu_pcfifo_ren,
   output logic                 cp0_pcfifo_busy,
   output logic                 dm_dump_vld,
   output logic [DATAW-1:0]     dm_dump_data,
   output logic                 dm_dump_done,
   output logic                 dm_dump_abort
);

   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

   dump_state_e          state;
   dump_state_e          state_nxt;
   logic [CNT_WIDTH-1:0] remain;
   logic [CNT_WIDTH-1:0] remain_nxt;
   logic                 abort_q;
   logic                 abort_nxt;
   logic                 armed;

   logic                 csr_hit;
   logic                 in_idle;
   logic                 dump_kill;
   logic                 clk_en;
   logic [CNT_WIDTH-1:0] cnt_sat;

   assign csr_hit   = cp0_dtu_rreg && (cp0_dtu_addr == CSR_PCFIFO);
   assign in_idle   = (state == IDLE);
   assign dump_kill = rtu_dtu_halt_ack || !had_dbg_mode;
   assign clk_en    = !in_idle || dm_dump_req;
   assign cnt_sat   = (dm_dump_cnt > DEPTH_C) ? DEPTH_C : dm_dump_cnt;

   // State only moves while a dump is active or being requested.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state   <= IDLE;
         remain  <= '0;
         abort_q <= 1'b0;
      end else if (clk_en) begin
         state   <= state_nxt;
         remain  <= remain_nxt;
         abort_q <= abort_nxt;
      end
   end

   // A held request must be seen low before another dump may start.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         armed <= 1'b1;
      end else if (state == DONE) begin
         armed <= !dm_dump_req;
      end else if (in_idle && !dm_dump_req) begin
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt       = state;
      remain_nxt      = remain;
      abort_nxt       = abort_q;
      dtu_pcfifo_frz  = 1'b0;
      dtu_pcfifo_ren  = 1'b0;
      cp0_pcfifo_busy = 1'b0;
      dm_dump_vld     = 1'b0;
      dm_dump_data    = '0;
      dm_dump_done    = 1'b0;
      dm_dump_abort   = 1'b0;
      unique case (state)
         IDLE: begin
            dtu_pcfifo_frz = cp0_sw_pcfifo_frz;
            dtu_pcfifo_ren = csr_hit && !cp0_sw_pcfifo_frz;
            abort_nxt      = 1'b0;
            if (dm_dump_req && had_dbg_mode && armed) begin
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            cp0_pcfifo_busy = csr_hit;
            if (dump_kill) begin
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end else if (dm_dump_cnt == '0) begin
               state_nxt = DONE;
            end else begin
               remain_nxt = cnt_sat;
               state_nxt  = DUMP;
            end
         end
         DUMP: begin
            cp0_pcfifo_busy = csr_hit;
            dm_dump_vld     = 1'b1;
            dm_dump_data    = pcfifo_regs_data;
            // Abort wins over a same-cycle handshake.
            if (dump_kill) begin
               abort_nxt = 1'b1;
               state_nxt = DONE;
            end else if (dm_dump_rdy && remain != '0) begin
               dtu_pcfifo_ren = 1'b1;
               remain_nxt     = remain - ONE_C;
               if (remain == ONE_C) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            cp0_pcfifo_busy = csr_hit;
            dm_dump_done    = 1'b1;
            dm_dump_abort   = abort_q;
            remain_nxt      = '0;
            state_nxt       = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Outputs fall immediately with reset, not at the next edge.
      if (!cpurst_b) begin
         dtu_pcfifo_frz  = 1'b0;
         dtu_pcfifo_ren  = 1'b0;
         cp0_pcfifo_busy = 1'b0;
         dm_dump_vld     = 1'b0;
         dm_dump_data    = '0;
         dm_dump_done    = 1'b0;
         dm_dump_abort   = 1'b0;
      end
   end

endmodule

// File: tb/tb_aq_dtu_pcfifo_dump_ctrl.sv
// Directed + randomized bench with a 16-entry FIFO model and dump scoreboard.
module tb_aq_dtu_pcfifo_dump_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rreg;
   logic [11:0] addr;
   logic        sw_frz;
   logic        dbg;
   logic        halt_ack;
   logic        req;
   logic [4:0]  cnt;
   logic        rdy;
   logic [63:0] regs_data;
   logic        frz;
   logic        ren;
   logic        busy;
   logic        vld;
   logic [63:0] data;
   logic        done;
   logic        abort;

   logic [63:0] mem [16];
   logic [3:0]  rptr = 4'd0;
   int          ren_total = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   assign regs_data = mem[rptr];

   always @(posedge clk) begin
      if (ren) begin
         rptr      <= rptr + 4'd1;
         ren_total <= ren_total + 1;
      end
   end

   aq_dtu_pcfifo_dump_ctrl dut (
      .forever_cpuclk    (clk),
      .cpurst_b          (rst_n),
      .cp0_dtu_rreg      (rreg),
      .cp0_dtu_addr      (addr),
      .cp0_sw_pcfifo_frz (sw_frz),
      .had_dbg_mode      (dbg),
      .rtu_dtu_halt_ack  (halt_ack),
      .dm_dump_req       (req),
      .dm_dump_cnt       (cnt),
      .dm_dump_rdy       (rdy),
      .pcfifo_regs_data  (regs_data),
      .dtu_pcfifo_frz    (frz),
      .dtu_pcfifo_ren    (ren),
      .cp0_pcfifo_busy   (busy),
      .dm_dump_vld       (vld),
      .dm_dump_data      (data),
      .dm_dump_done      (done),
      .dm_dump_abort     (abort)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected: min(n,16) handshakes returning consecutive FIFO slots.
   task automatic do_dump(input int n, input logic [31:0] mask,
                          input bit use_rand);
      int   exp_n;
      int   got;
      int   cyc;
      int   ren0;
      int   start;
      logic r;
      exp_n = (n > 16) ? 16 : n;
      got   = 0;
      cyc   = 0;
      req   = 1'b1;
      dbg   = 1'b1;
      cnt   = 5'(n);
      @(negedge clk);
      chk("idle_vld", 64'(vld), 64'd0);
      tick();
      req = 1'b0;
      @(negedge clk);
      chk("sync_vld", 64'(vld), 64'd0);
      chk("sync_ren", 64'(ren), 64'd0);
      start = int'(rptr);
      ren0  = ren_total;
      tick();
      while (got < exp_n && cyc < 200) begin
         r   = use_rand ? 1'($urandom_range(0, 1)) : mask[cyc % 32];
         rdy = r;
         @(negedge clk);
         chk("dump_vld", 64'(vld), 64'd1);
         chk("dump_data", data, mem[(start + got) % 16]);
         chk("dump_ren", 64'(ren), 64'(r));
         if (r) got++;
         cyc++;
         tick();
      end
      chk("dump_count", 64'(got), 64'(exp_n));
      rdy = 1'b0;
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_abort", 64'(abort), 64'd0);
      chk("done_vld", 64'(vld), 64'd0);
      chk("done_ren", 64'(ren), 64'd0);
      tick();
      @(negedge clk);
      chk("done_clear", 64'(done), 64'd0);
      chk("ren_pulses", 64'(ren_total - ren0), 64'(exp_n));
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int ren0;
      logic [3:0] p0;
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      rst_n    = 1'b0;
      rreg     = 1'b1;
      addr     = 12'hfe2;
      sw_frz   = 1'b1;
      dbg      = 1'b0;
      halt_ack = 1'b0;
      req      = 1'b0;
      cnt      = 5'd0;
      rdy      = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_frz", 64'(frz), 64'd0);
      chk("rst_ren", 64'(ren), 64'd0);
      chk("rst_vld", 64'(vld), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_data", data, 64'd0);
      tick();
      rst_n  = 1'b1;
      sw_frz = 1'b0;
      @(negedge clk);
      chk("csr_ren", 64'(ren), 64'd1);
      chk("csr_busy", 64'(busy), 64'd0);
      chk("csr_frz0", 64'(frz), 64'd0);
      tick();
      sw_frz = 1'b1;
      @(negedge clk);
      chk("frz_ren", 64'(ren), 64'd0);
      chk("frz_out", 64'(frz), 64'd1);
      tick();
      sw_frz = 1'b0;
      addr   = 12'hfe1;
      @(negedge clk);
      chk("csr_other_ren", 64'(ren), 64'd0);
      tick();
      rreg = 1'b0;
      addr = 12'hfe2;

      // Request without debug mode is ignored.
      req = 1'b1;
      cnt = 5'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nodbg_vld", 64'(vld), 64'd0);
         chk("nodbg_done", 64'(done), 64'd0);
         tick();
      end
      req = 1'b0;
      tick();

      do_dump(4, 32'hffff_ffff, 1'b0);
      do_dump(20, 32'hffff_ffff, 1'b0);
      do_dump(0, 32'hffff_ffff, 1'b0);
      do_dump(3, 32'b11001, 1'b0);

      // CSR hit during dump, then halt_ack aborts a ready handshake.
      ren0 = ren_total;
      p0   = rptr;
      req  = 1'b1;
      dbg  = 1'b1;
      cnt  = 5'd8;
      tick();
      req = 1'b0;
      tick();
      rreg = 1'b1;
      @(negedge clk);
      chk("dump_busy", 64'(busy), 64'd1);
      chk("dump_csr_ren", 64'(ren), 64'd0);
      tick();
      rreg     = 1'b0;
      rdy      = 1'b1;
      halt_ack = 1'b1;
      @(negedge clk);
      chk("halt_ren", 64'(ren), 64'd0);
      tick();
      halt_ack = 1'b0;
      rdy      = 1'b0;
      @(negedge clk);
      chk("halt_done", 64'(done), 64'd1);
      chk("halt_abort", 64'(abort), 64'd1);
      tick();
      @(negedge clk);
      chk("halt_done_clr", 64'(done), 64'd0);
      chk("halt_no_ren", 64'(ren_total - ren0), 64'd0);
      chk("halt_rptr", 64'(rptr), 64'(p0));
      tick();

      // Debug mode drops after one handshake.
      ren0 = ren_total;
      req  = 1'b1;
      cnt  = 5'd6;
      tick();
      req = 1'b0;
      tick();
      rdy = 1'b1;
      tick();
      dbg = 1'b0;
      @(negedge clk);
      chk("dbgfall_ren", 64'(ren), 64'd0);
      tick();
      rdy = 1'b0;
      @(negedge clk);
      chk("dbgfall_done", 64'(done), 64'd1);
      chk("dbgfall_abort", 64'(abort), 64'd1);
      tick();
      chk("dbgfall_pulses", 64'(ren_total - ren0), 64'd1);
      dbg = 1'b1;
      tick();

      // Reset in the middle of a dump.
      req = 1'b1;
      cnt = 5'd10;
      tick();
      req = 1'b0;
      tick();
      rdy    = 1'b1;
      sw_frz = 1'b1;
      @(negedge clk);
      chk("pre_rst_vld", 64'(vld), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 64'(vld), 64'd0);
      chk("arst_ren", 64'(ren), 64'd0);
      chk("arst_frz", 64'(frz), 64'd0);
      chk("arst_data", data, 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      rdy = 1'b0;
      tick();
      rst_n  = 1'b1;
      sw_frz = 1'b0;
      rreg   = 1'b1;
      @(negedge clk);
      chk("post_rst_ren", 64'(ren), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_done", 64'(done), 64'd0);
      tick();
      rreg = 1'b0;
      do_dump(5, 32'hffff_ffff, 1'b0);

      for (int k = 0; k < 6; k++) begin
         do_dump(int'($urandom_range(0, 31)), 32'd0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
